// File: rtl/alu_reg_sequencer.sv
// Command-driven sequencer that reads two registers, runs the ALU and writes the result back.
// Optional macro WIDE_WB_EN: multiply results also write their high word to register rd+1.
`timescale 1ns/1ps
module alu_reg_sequencer #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [AW-1:0]     cmd_rs1,
    input  logic [AW-1:0]     cmd_rs2,
    input  logic [AW-1:0]     cmd_rd,
    input  logic              cmd_wb,
    output logic [AW-1:0]     rf_readreg1,
    output logic [AW-1:0]     rf_readreg2,
    input  logic [DW-1:0]     rf_rd1,
    input  logic [DW-1:0]     rf_rd2,
    output logic [3:0]        alu_op,
    input  logic [2*DW-1:0]   alu_out,
    output logic [AW-1:0]     rf_writereg,
    output logic              rf_wr_op,
    output logic [DW-1:0]     rf_data_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*DW-1:0]   rsp_result,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    localparam logic [3:0] OP_DIV = 4'b0011;
`ifdef WIDE_WB_EN
    localparam logic [3:0] OP_MUL = 4'b0010;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB,
`ifdef WIDE_WB_EN
        ST_WB_HI,
`endif
        ST_RESP
    } state_t;

    state_t              r_state, w_state_next;
    logic [3:0]          r_op, w_op_next;
    logic [AW-1:0]       r_rd, w_rd_next;
    logic                r_wb, w_wb_next;
    logic                r_err, w_err_next;
    logic [2*DW-1:0]     r_result, w_result_next;
    logic                r_cmd_ready, w_cmd_ready_next;
    logic                r_busy, w_busy_next;
    logic                r_rsp_valid, w_rsp_valid_next;
    logic                r_rf_wr_op, w_rf_wr_op_next;
    logic [AW-1:0]       r_readreg1, w_readreg1_next;
    logic [AW-1:0]       r_readreg2, w_readreg2_next;
    logic [AW-1:0]       r_writereg, w_writereg_next;
    logic [DW-1:0]       r_data_in, w_data_in_next;
    logic [3:0]          r_alu_op, w_alu_op_next;
    logic [CNT_W-1:0]    r_ops_done, w_ops_done_next;
    logic                w_div0;

    // Read addresses are held from acceptance through EXEC, so rf_rd2 is still valid here.
    assign w_div0 = (r_op == OP_DIV) && (rf_rd2 == '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_rd        <= '0;
            r_wb        <= 1'b0;
            r_err       <= 1'b0;
            r_result    <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rf_wr_op  <= 1'b0;
            r_readreg1  <= '0;
            r_readreg2  <= '0;
            r_writereg  <= '0;
            r_data_in   <= '0;
            r_alu_op    <= '0;
            r_ops_done  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_op        <= w_op_next;
            r_rd        <= w_rd_next;
            r_wb        <= w_wb_next;
            r_err       <= w_err_next;
            r_result    <= w_result_next;
            r_cmd_ready <= w_cmd_ready_next;
            r_busy      <= w_busy_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rf_wr_op  <= w_rf_wr_op_next;
            r_readreg1  <= w_readreg1_next;
            r_readreg2  <= w_readreg2_next;
            r_writereg  <= w_writereg_next;
            r_data_in   <= w_data_in_next;
            r_alu_op    <= w_alu_op_next;
            r_ops_done  <= w_ops_done_next;
        end
    end

    // Every output is a flop, so its next value is decoded from the state being entered.
    always_comb begin
        w_state_next     = r_state;
        w_op_next        = r_op;
        w_rd_next        = r_rd;
        w_wb_next        = r_wb;
        w_err_next       = r_err;
        w_result_next    = r_result;
        w_cmd_ready_next = 1'b0;
        w_busy_next      = 1'b1;
        w_rsp_valid_next = 1'b0;
        w_rf_wr_op_next  = 1'b0;
        w_readreg1_next  = r_readreg1;
        w_readreg2_next  = r_readreg2;
        w_writereg_next  = r_writereg;
        w_data_in_next   = r_data_in;
        w_alu_op_next    = r_alu_op;
        w_ops_done_next  = r_ops_done;

        case (r_state)
            ST_IDLE: begin
                w_busy_next      = 1'b0;
                w_cmd_ready_next = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_state_next     = ST_READ;
                    w_busy_next      = 1'b1;
                    w_cmd_ready_next = 1'b0;
                    w_op_next        = cmd_op;
                    w_rd_next        = cmd_rd;
                    w_wb_next        = cmd_wb;
                    w_readreg1_next  = cmd_rs1;
                    w_readreg2_next  = cmd_rs2;
                end
            end
            ST_READ: begin
                w_state_next  = ST_EXEC;
                w_alu_op_next = r_op;
            end
            ST_EXEC: begin
                w_state_next    = ST_WB;
                w_alu_op_next   = '0;
                w_err_next      = w_div0;
                w_result_next   = w_div0 ? '1 : alu_out;
                w_rf_wr_op_next = r_wb && !w_div0;
                w_writereg_next = r_rd;
                w_data_in_next  = w_div0 ? '1 : alu_out[DW-1:0];
            end
            ST_WB: begin
`ifdef WIDE_WB_EN
                if ((r_op == OP_MUL) && r_wb) begin
                    w_state_next    = ST_WB_HI;
                    w_rf_wr_op_next = 1'b1;
                    w_writereg_next = r_rd + AW'(1);
                    w_data_in_next  = r_result[2*DW-1:DW];
                end else
`endif
                begin
                    w_state_next     = ST_RESP;
                    w_rsp_valid_next = 1'b1;
                end
            end
`ifdef WIDE_WB_EN
            ST_WB_HI: begin
                w_state_next     = ST_RESP;
                w_rsp_valid_next = 1'b1;
            end
`endif
            ST_RESP: begin
                w_rsp_valid_next = 1'b1;
                if (rsp_ready) begin
                    w_state_next     = ST_IDLE;
                    w_rsp_valid_next = 1'b0;
                    w_busy_next      = 1'b0;
                    w_cmd_ready_next = 1'b1;
                    w_ops_done_next  = r_ops_done + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign cmd_ready   = r_cmd_ready;
    assign busy        = r_busy;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_result;
    assign rsp_err     = r_err;
    assign rf_wr_op    = r_rf_wr_op;
    assign rf_readreg1 = r_readreg1;
    assign rf_readreg2 = r_readreg2;
    assign rf_writereg = r_writereg;
    assign rf_data_in  = r_data_in;
    assign alu_op      = r_alu_op;
    assign ops_done    = r_ops_done;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer with a behavioural register file and ALU around it.
// Expected values follow WIDE_WB_EN when that macro is defined for the build.
`timescale 1ns/1ps
module tb_alu_reg_sequencer;

`ifdef WIDE_WB_EN
    localparam int WIDE = 1;
`else
    localparam int WIDE = 0;
`endif

    logic        clk;
    logic        clr_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rs1, cmd_rs2, cmd_rd;
    logic        cmd_wb;
    logic [4:0]  rf_readreg1, rf_readreg2, rf_writereg;
    logic [31:0] rf_rd1, rf_rd2, rf_data_in;
    logic [3:0]  alu_op;
    logic [63:0] alu_out;
    logic        rf_wr_op;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [63:0] rsp_result;
    logic [15:0] ops_done;

    logic [31:0] rf_mem [32];
    logic        pk_en;
    logic [4:0]  pk_addr;
    logic [31:0] pk_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int prev_hs = 0;
    int ops_exp = 0;

    alu_reg_sequencer dut (
        .clk(clk), .clr_n(clr_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_wb(cmd_wb),
        .rf_readreg1(rf_readreg1), .rf_readreg2(rf_readreg2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .alu_op(alu_op), .alu_out(alu_out),
        .rf_writereg(rf_writereg), .rf_wr_op(rf_wr_op), .rf_data_in(rf_data_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rf_wr_op) rf_mem[rf_writereg] <= rf_data_in;
        else if (pk_en) rf_mem[pk_addr] <= pk_data;
    end
    assign rf_rd1 = rf_mem[rf_readreg1];
    assign rf_rd2 = rf_mem[rf_readreg2];

    // Divide by zero returns 0 here so the forced all-ones result is visibly the controller's doing.
    always_comb begin
        case (alu_op)
            4'b0000: alu_out = {32'd0, rf_rd1} + {32'd0, rf_rd2};
            4'b0001: alu_out = {32'd0, rf_rd1 - rf_rd2};
            4'b0010: alu_out = {32'd0, rf_rd1} * {32'd0, rf_rd2};
            4'b0011: alu_out = (rf_rd2 == 32'd0) ? 64'd0 : {32'd0, rf_rd1 / rf_rd2};
            default: alu_out = 64'd0;
        endcase
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        pk_addr = a;
        pk_data = d;
        pk_en   = 1'b1;
        @(posedge clk);
        #1;
        pk_en   = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic wb,
                         input logic keep_valid, input logic check_gap, input int rsp_delay,
                         input logic [63:0] exp_result, input logic exp_err);
        logic       exp_wr, exp_hi;
        logic [4:0] rd_hi;
        int         hs;
        int         budget;
        exp_wr = wb && !exp_err;
        exp_hi = (WIDE != 0) && (op == 4'b0010) && wb;
        rd_hi  = rd + 5'd1;
        cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_wb = wb;
        cmd_valid = 1'b1;
        rsp_ready = (rsp_delay == 0);
        budget = 0;
        @(negedge clk);
        while (!cmd_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check_value({tag, ".accept"}, 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        hs = cyc;
        if (!keep_valid) cmd_valid = 1'b0;
        if (check_gap) check_value({tag, ".gap"}, 64'(hs - prev_hs), 64'd5);
        prev_hs = hs;

        @(negedge clk);
        check_value({tag, ".read_busy"}, 64'({busy, cmd_ready}), 64'b10);
        check_value({tag, ".read_addr"}, 64'({rf_readreg1, rf_readreg2}), 64'({rs1, rs2}));
        @(negedge clk);
        check_value({tag, ".exec"}, 64'({alu_op, rf_wr_op}), 64'({op, 1'b0}));
        @(negedge clk);
        check_value({tag, ".wb_en"}, 64'(rf_wr_op), 64'(exp_wr));
        if (exp_wr) begin
            check_value({tag, ".wb_addr"}, 64'(rf_writereg), 64'(rd));
            check_value({tag, ".wb_data"}, 64'(rf_data_in), 64'(exp_result[31:0]));
        end
        if (exp_hi) begin
            @(negedge clk);
            check_value({tag, ".wbhi_en"}, 64'(rf_wr_op), 64'd1);
            check_value({tag, ".wbhi_addr"}, 64'(rf_writereg), 64'(rd_hi));
            check_value({tag, ".wbhi_data"}, 64'(rf_data_in), 64'(exp_result[63:32]));
        end
        @(negedge clk);
        check_value({tag, ".rsp_valid"}, 64'({rsp_valid, rf_wr_op, cmd_ready}), 64'b100);
        check_value({tag, ".rsp_result"}, rsp_result, exp_result);
        check_value({tag, ".rsp_err"}, 64'(rsp_err), 64'(exp_err));
        for (int i = 0; i < rsp_delay; i++) begin
            @(negedge clk);
            check_value({tag, ".hold_ctl"}, 64'({rsp_valid, cmd_ready}), 64'b10);
            check_value({tag, ".hold_res"}, rsp_result, exp_result);
            check_value({tag, ".hold_cnt"}, 64'(ops_done), 64'(ops_exp));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        ops_exp = ops_exp + 1;
        check_value({tag, ".ops_done"}, 64'(ops_done), 64'(ops_exp));
        check_value({tag, ".to_idle"}, 64'({rsp_valid, cmd_ready, busy}), 64'b010);
        $display("txn %s: op=%h rs1=%0d rs2=%0d rd=%0d wb=%b result=%h err=%b ops_done=%0d",
                 tag, op, rs1, rs2, rd, wb, rsp_result, rsp_err, ops_done);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_rd = '0; cmd_wb = 1'b0; rsp_ready = 1'b0; pk_en = 1'b0; pk_addr = '0; pk_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst.ctrl", 64'({cmd_ready, busy, rf_wr_op, rsp_valid, rsp_err}), 64'd0);
        check_value("rst.data", rsp_result | 64'(ops_done), 64'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check_value("rst.release_ready", 64'(cmd_ready), 64'd1);
        $display("txn reset: cmd_ready=%b ops_done=%0d", cmd_ready, ops_done);

        // T2 add
        poke(5'd1, 32'd5); poke(5'd2, 32'd7); poke(5'd3, 32'd0);
        do_op("t2_add", 4'b0000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 0, 64'd12, 1'b0);
        check_value("t2.r3", 64'(rf_mem[3]), 64'd12);

        // T3 divide by zero
        poke(5'd4, 32'd100); poke(5'd5, 32'd0); poke(5'd6, 32'h1234);
        do_op("t3_div0", 4'b0011, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 0, {64{1'b1}}, 1'b1);
        check_value("t3.r6", 64'(rf_mem[6]), 64'h1234);

        // T4 backpressure: r3 - r1 = 12 - 5
        do_op("t4_bp", 4'b0001, 5'd3, 5'd1, 5'd10, 1'b1, 1'b0, 1'b0, 10, 64'd7, 1'b0);
        check_value("t4.r10", 64'(rf_mem[10]), 64'd7);

        // T5 multiply into r31, high word lands in r0 only with the wide write-back
        poke(5'd1, 32'h0001_0000); poke(5'd2, 32'h0001_0000);
        poke(5'd31, 32'hFFFF); poke(5'd0, 32'hABCD);
        do_op("t5_mul", 4'b0010, 5'd1, 5'd2, 5'd31, 1'b1, 1'b0, 1'b0, 0, 64'h1_0000_0000, 1'b0);
        check_value("t5.r31", 64'(rf_mem[31]), 64'd0);
        check_value("t5.r0", 64'(rf_mem[0]), (WIDE != 0) ? 64'd1 : 64'hABCD);

        // compute-only: no write-back
        poke(5'd11, 32'h55);
        do_op("nowb", 4'b0000, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0, 1'b0, 0, 64'h2_0000, 1'b0);
        check_value("nowb.r11", 64'(rf_mem[11]), 64'h55);

        // T1 reset in the middle of EXEC
        poke(5'd9, 32'hDEAD);
        cmd_op = 4'b0001; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_rd = 5'd9; cmd_wb = 1'b1;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        check_value("t1.accept", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check_value("t1.in_exec", 64'(alu_op), 64'd1);
        #1;
        clr_n = 1'b0;
        #1;
        check_value("t1.ctrl_zero", 64'({cmd_ready, busy, rf_wr_op, rsp_valid, rsp_err, alu_op}), 64'd0);
        check_value("t1.addr_zero", 64'({rf_readreg1, rf_readreg2, rf_writereg}), 64'd0);
        check_value("t1.data_zero", 64'(rf_data_in), 64'd0);
        check_value("t1.result_zero", rsp_result, 64'd0);
        check_value("t1.ops_zero", 64'(ops_done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("t1.held", 64'({rf_wr_op, cmd_ready, rsp_valid}), 64'd0);
        end
        clr_n = 1'b1;
        ops_exp = 0;
        @(posedge clk);
        #1;
        check_value("t1.ready_after", 64'(cmd_ready), 64'd1);
        check_value("t1.ops_after", 64'(ops_done), 64'd0);
        check_value("t1.r9", 64'(rf_mem[9]), 64'hDEAD);
        $display("txn t1_reset: aborted sub into r9, r9=%h ops_done=%0d", rf_mem[9], ops_done);

        // T6 back-to-back with cmd_valid held high; first op overwrites its own source
        poke(5'd1, 32'd10); poke(5'd2, 32'd3);
        do_op("t6_a", 4'b0000, 5'd1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b0, 0, 64'd13, 1'b0);
        do_op("t6_b", 4'b0001, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 0, 64'd10, 1'b0);
        do_op("t6_c", 4'b0000, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1, 0, 64'd23, 1'b0);
        check_value("t6.r1", 64'(rf_mem[1]), 64'd13);
        check_value("t6.r7", 64'(rf_mem[7]), 64'd10);
        check_value("t6.r8", 64'(rf_mem[8]), 64'd23);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
